fifo_req_sched: RTL and testbench

//  Round-robin scheduler that shares one 8-entry FIFO datapath among two writers (W0, W1) and one reader (R).
//  It issues at most one FIFO operation per cycle on fifo_op, using the FIFO state encoding: 000 idle, 001 write, 010 read.
//  It keeps a shadow occupancy count, so it never issues a write when the FIFO is full or a read when it is empty.
//  The downstream head/tail/count logic therefore never sees a blocked request.

---
 rtl/fifo_req_sched_if.sv | 31 +++
 rtl/fifo_req_sched.sv | 115 +++++++++++
 tb/tb_fifo_req_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_req_sched_if.sv
// Handshake bundle between the writers/reader and the FIFO request scheduler.
interface fifo_req_sched_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 4
);
   logic                  w0_req;
   logic [DATA_WIDTH-1:0] w0_din;
   logic                  w1_req;
   logic [DATA_WIDTH-1:0] w1_din;
   logic                  r_req;
   logic                  w0_ack;
   logic                  w1_ack;
   logic                  r_ack;
   logic [2:0]            fifo_op;
   logic [DATA_WIDTH-1:0] fifo_din;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  empty;

   // requester / FIFO side
   modport master (
      output w0_req, w0_din, w1_req, w1_din, r_req,
      input  w0_ack, w1_ack, r_ack, fifo_op, fifo_din, count, full, empty
   );

   // scheduler side
   modport slave (
      input  w0_req, w0_din, w1_req, w1_din, r_req,
      output w0_ack, w1_ack, r_ack, fifo_op, fifo_din, count, full, empty
   );
endinterface

// File: rtl/fifo_req_sched.sv
// Round-robin scheduler sharing one FIFO datapath between two writers and a
// reader. A shadow occupancy count keeps blocked operations from ever being
// issued; every output is a register loaded from the decision of the cycle before.
module fifo_req_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   fifo_req_sched_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      WRITE = 3'b001,
      READ  = 3'b010
   } state_t;

   // ring positions, also used as ack bit indices
   localparam logic [1:0] P_W0 = 2'd0;
   localparam logic [1:0] P_W1 = 2'd1;
   localparam logic [1:0] P_R  = 2'd2;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t                state, state_nxt;
   logic [1:0]            last, last_nxt;
   logic [2:0]            ack, ack_nxt;
   logic [DATA_WIDTH-1:0] din_q, din_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  full_q, full_nxt;
   logic                  empty_q, empty_nxt;
   logic [2:0]            elig;
   logic [2:0][1:0]       ord;
   logic                  win_vld;
   logic [1:0]            win;

   // eligibility: an item acked this cycle is stale and sits out one cycle
   always_comb begin
      elig[P_W0] = bus.w0_req & ~ack[P_W0] & (cnt < DEPTH_C);
      elig[P_W1] = bus.w1_req & ~ack[P_W1] & (cnt < DEPTH_C);
      elig[P_R]  = bus.r_req  & ~ack[P_R]  & (cnt != '0);
   end

   // round-robin pick starting after the last grant, then next-state/outputs
   always_comb begin
      state_nxt = IDLE;
      last_nxt  = last;
      ack_nxt   = '0;
      din_nxt   = '0;
      cnt_nxt   = cnt;
      win_vld   = 1'b0;
      win       = P_R;
      // ord[0] is searched first
      case (last)
         P_W0:    ord = {P_W0, P_R,  P_W1};
         P_W1:    ord = {P_W1, P_W0, P_R};
         default: ord = {P_R,  P_W1, P_W0};
      endcase
      // walk from the back so the earliest eligible entry is left in win
      for (int k = 2; k >= 0; k--) begin
         if (elig[ord[k]]) begin
            win_vld = 1'b1;
            win     = ord[k];
         end
      end
      if (win_vld) begin
         last_nxt     = win;
         ack_nxt[win] = 1'b1;
         if (win == P_R) begin
            state_nxt = READ;
            cnt_nxt   = cnt - 1'b1;
         end else begin
            state_nxt = WRITE;
            cnt_nxt   = cnt + 1'b1;
            din_nxt   = (win == P_W0) ? bus.w0_din : bus.w1_din;
         end
      end
      full_nxt  = (cnt_nxt == DEPTH_C);
      empty_nxt = (cnt_nxt == '0);
   end

   // state and output registers; clear flushes exactly like reset
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state   <= IDLE;
         last    <= P_R;
         ack     <= '0;
         din_q   <= '0;
         cnt     <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         last    <= last_nxt;
         ack     <= ack_nxt;
         din_q   <= din_nxt;
         cnt     <= cnt_nxt;
         full_q  <= full_nxt;
         empty_q <= empty_nxt;
      end
   end

   assign bus.fifo_op  = state;
   assign bus.fifo_din = din_q;
   assign bus.w0_ack   = ack[P_W0];
   assign bus.w1_ack   = ack[P_W1];
   assign bus.r_ack    = ack[P_R];
   assign bus.count    = cnt;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;

endmodule

// File: tb/tb_fifo_req_sched.sv
// Bench for fifo_req_sched: directed vector table, hand sequences for the
// corner cases, then randomized traffic against a queue-based reference.
module tb_fifo_req_sched;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic clk = 1'b0;
   logic reset;
   logic clear;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fifo_req_sched_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

   fifo_req_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .bus  (bus)
   );

   typedef struct {
      logic          rst, clr, w0, w1, r;
      logic [DW-1:0] d0, d1;
      logic [2:0]    op;
      logic [DW-1:0] din;
      logic          a0, a1, ar;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, clr, w0, input logic [DW-1:0] d0,
                               input logic w1, input logic [DW-1:0] d1, input logic r,
                               input logic [2:0] op, input logic [DW-1:0] din,
                               input logic a0, a1, ar, input int cnt);
      vec_t v;
      v.rst = rst; v.clr = clr; v.w0 = w0; v.d0 = d0; v.w1 = w1; v.d1 = d1; v.r = r;
      v.op = op; v.din = din; v.a0 = a0; v.a1 = a1; v.ar = ar; v.cnt = CW'(cnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      reset = v.rst; clear = v.clr;
      bus.w0_req = v.w0; bus.w0_din = v.d0;
      bus.w1_req = v.w1; bus.w1_din = v.d1;
      bus.r_req  = v.r;
      @(posedge clk); #1;
      chk({tag, " op"},    32'(bus.fifo_op),  32'(v.op));
      chk({tag, " din"},   bus.fifo_din,      v.din);
      chk({tag, " w0ack"}, 32'(bus.w0_ack),   32'(v.a0));
      chk({tag, " w1ack"}, 32'(bus.w1_ack),   32'(v.a1));
      chk({tag, " rack"},  32'(bus.r_ack),    32'(v.ar));
      chk({tag, " count"}, 32'(bus.count),    32'(v.cnt));
      chk({tag, " full"},  32'(bus.full),     32'(v.cnt == CW'(DEPTH)));
      chk({tag, " empty"}, 32'(bus.empty),    32'(v.cnt == '0));
   endtask

   // reference: the FIFO contents as a queue, the ring as indices 0/1/2
   logic [DW-1:0] mq[$];
   int            m_last;
   bit [2:0]      m_ack;
   logic [2:0]    e_op;
   logic [DW-1:0] e_din;

   task automatic model_edge();
      bit [2:0] req;
      int       win, idx;
      bit       ok;
      if (reset || clear) begin
         mq.delete(); m_last = 2; m_ack = '0; e_op = 3'b000; e_din = '0;
         return;
      end
      req = {bus.r_req, bus.w1_req, bus.w0_req};
      win = -1;
      for (int k = 1; k <= 3; k++) begin
         idx = (m_last + k) % 3;
         ok  = req[idx] && !m_ack[idx] &&
               ((idx == 2) ? (mq.size() > 0) : (mq.size() < DEPTH));
         if (ok && win < 0) win = idx;
      end
      m_ack = '0; e_op = 3'b000; e_din = '0;
      if (win == 2) begin
         void'(mq.pop_front());
         e_op = 3'b010;
      end else if (win >= 0) begin
         e_din = (win == 0) ? bus.w0_din : bus.w1_din;
         mq.push_back(e_din);
         e_op = 3'b001;
      end
      if (win >= 0) begin
         m_ack[win] = 1'b1;
         m_last     = win;
      end
   endtask

   initial begin
      int wp, rp;
      reset = 1'b1; clear = 1'b0;
      bus.w0_req = 0; bus.w1_req = 0; bus.r_req = 0; bus.w0_din = '0; bus.w1_din = '0;

      // reset, then W0 fills the FIFO; each held req after an ack is a new item
      tbl.push_back(mk(1,0, 0,0, 0,0, 0, 3'b000,0, 0,0,0, 0));
      for (int k = 1; k <= 8; k++) begin
         tbl.push_back(mk(0,0, 1,k, 0,0, 0, 3'b001,k, 1,0,0, k));
         tbl.push_back(mk(0,0, 1,k, 0,0, 0, 3'b000,0, 0,0,0, k));
      end
      tbl.push_back(mk(0,0, 1,9, 0,0, 0, 3'b000,0, 0,0,0, 8));
      tbl.push_back(mk(0,0, 1,9, 0,0, 0, 3'b000,0, 0,0,0, 8));
      // drain with r_req held: reads on alternate cycles down to empty
      for (int k = 7; k >= 0; k--) begin
         tbl.push_back(mk(0,0, 0,0, 0,0, 1, 3'b010,0, 0,0,1, k));
         tbl.push_back(mk(0,0, 0,0, 0,0, 1, 3'b000,0, 0,0,0, k));
      end
      tbl.push_back(mk(0,0, 0,0, 0,0, 1, 3'b000,0, 0,0,0, 0));
      // all three held from empty: W0,W1,R,W0,W1,R
      tbl.push_back(mk(0,0, 1,32'hA1, 1,32'hB1, 1, 3'b001,32'hA1, 1,0,0, 1));
      tbl.push_back(mk(0,0, 1,32'hA2, 1,32'hB1, 1, 3'b001,32'hB1, 0,1,0, 2));
      tbl.push_back(mk(0,0, 1,32'hA2, 1,32'hB2, 1, 3'b010,0,      0,0,1, 1));
      tbl.push_back(mk(0,0, 1,32'hA2, 1,32'hB2, 1, 3'b001,32'hA2, 1,0,0, 2));
      tbl.push_back(mk(0,0, 1,32'hA3, 1,32'hB2, 1, 3'b001,32'hB2, 0,1,0, 3));
      tbl.push_back(mk(0,0, 1,32'hA3, 1,32'hB3, 1, 3'b010,0,      0,0,1, 2));

      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

      // count=7 with the pointer after W0: W1 wins, W0 waits for a read
      for (int k = 0; k < 5; k++) begin
         apply(mk(0,0, 1,32'hE0+k, 0,0, 0, 3'b001,32'hE0+k, 1,0,0, 3+k), "fill w");
         apply(mk(0,0, 1,32'hE0+k, 0,0, 0, 3'b000,0,        0,0,0, 3+k), "fill i");
      end
      apply(mk(0,0, 1,32'hE5, 1,32'hF0, 0, 3'b001,32'hF0, 0,1,0, 8), "c4 w1 wins");
      apply(mk(0,0, 1,32'hE5, 0,0,      0, 3'b000,0,      0,0,0, 8), "c4 w0 blocked");
      apply(mk(0,0, 1,32'hE5, 0,0,      1, 3'b010,0,      0,0,1, 7), "c4 read");
      apply(mk(0,0, 1,32'hE5, 0,0,      0, 3'b001,32'hE5, 1,0,0, 8), "c4 w0 late");

      // clear while a write is presented at count=5
      apply(mk(1,0, 0,0, 0,0, 0, 3'b000,0, 0,0,0, 0), "c5 reset");
      for (int k = 1; k <= 4; k++) begin
         apply(mk(0,0, 1,32'h50+k, 0,0, 0, 3'b001,32'h50+k, 1,0,0, k), "c5 w");
         apply(mk(0,0, 1,32'h50+k, 0,0, 0, 3'b000,0,        0,0,0, k), "c5 i");
      end
      apply(mk(0,0, 1,32'h55, 0,0,      0, 3'b001,32'h55, 1,0,0, 5), "c5 w5");
      apply(mk(0,1, 1,32'h55, 1,32'h5F, 0, 3'b000,0,      0,0,0, 0), "c5 clear");
      apply(mk(0,0, 1,32'h56, 1,32'h5F, 0, 3'b001,32'h56, 1,0,0, 1), "c5 w0 first");

      // reset and clear together, requests held throughout
      apply(mk(0,0, 0,0, 1,32'h5F, 0, 3'b001,32'h5F, 0,1,0, 2), "c6 pre");
      for (int k = 0; k < 3; k++)
         apply(mk(1,1, 1,32'h61, 1,32'h62, 1, 3'b000,0, 0,0,0, 0), "c6 rst+clr");
      apply(mk(0,0, 1,32'h61, 1,32'h62, 1, 3'b001,32'h61, 1,0,0, 1), "c6 w0 first");

      // randomized traffic, alternating write-heavy and read-heavy phases
      for (int i = 0; i < 4000; i++) begin
         wp = ((i / 250) % 2 == 0) ? 3 : 1;
         rp = 4 - wp;
         reset = (i < 2) || ($urandom_range(0, 499) == 0);
         clear = ($urandom_range(0, 299) == 0);
         if (!bus.w0_req || bus.w0_ack) begin
            bus.w0_req = ($urandom_range(0, 3) < wp); bus.w0_din = $urandom;
         end
         if (!bus.w1_req || bus.w1_ack) begin
            bus.w1_req = ($urandom_range(0, 3) < wp); bus.w1_din = $urandom;
         end
         if (!bus.r_req || bus.r_ack)
            bus.r_req = ($urandom_range(0, 3) < rp);
         model_edge();
         @(posedge clk); #1;
         chk("rnd op",    32'(bus.fifo_op), 32'(e_op));
         chk("rnd din",   bus.fifo_din,     e_din);
         chk("rnd acks",  32'({bus.r_ack, bus.w1_ack, bus.w0_ack}), 32'(m_ack));
         chk("rnd count", 32'(bus.count),   32'(mq.size()));
         chk("rnd full",  32'(bus.full),    32'(mq.size() == DEPTH));
         chk("rnd empty", 32'(bus.empty),   32'(mq.size() == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
